// File: rtl/char_buffer_writer_pkg.sv
// rtl/char_buffer_writer_pkg.sv - shared text geometry, command codes and FSM states
// Geometry is shared with the video generator so both agree on the circular buffer layout.
package char_buffer_writer_pkg;

   localparam int ROWS          = 24;
   localparam int COLS          = 80;
   localparam int ROW_BITS      = 5;
   localparam int COL_BITS      = 7;
   localparam int ADDR_BITS     = 11;
   localparam int PAST_LAST_ROW = ROWS * COLS;

   localparam logic [7:0] FILL_CHAR = 8'h20;

   localparam logic [1:0] CMD_PUT          = 2'd0;
   localparam logic [1:0] CMD_SCROLL       = 2'd1;
   localparam logic [1:0] CMD_CLEAR_SCREEN = 2'd2;
   localparam logic [1:0] CMD_CLEAR_EOL    = 2'd3;

   typedef enum logic {
      ST_IDLE,
      ST_WRITE
   } state_t;

endpackage

// File: rtl/char_buffer_writer_if.sv
// rtl/char_buffer_writer_if.sv - terminal command valid/ready handshake
// The master is the terminal front end; the slave is the buffer writer.
interface char_buffer_writer_if;
   import char_buffer_writer_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd;
   logic [7:0]          cmd_char;
   logic [COL_BITS-1:0] cmd_x;
   logic [ROW_BITS-1:0] cmd_y;

   modport master (
      output cmd_valid,
      output cmd,
      output cmd_char,
      output cmd_x,
      output cmd_y,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd,
      input  cmd_char,
      input  cmd_x,
      input  cmd_y,
      output cmd_ready
   );

endinterface

// File: rtl/char_buffer_writer.sv
// rtl/char_buffer_writer.sv - turns terminal commands into character buffer write bursts
// Sole writer of the character buffer; owns the scroll base first_char.
module char_buffer_writer
   import char_buffer_writer_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   char_buffer_writer_if.slave   cmd_if,
   output logic [ADDR_BITS-1:0]  first_char,
   output logic                  wr_en,
   output logic [ADDR_BITS-1:0]  wr_addr,
   output logic [7:0]            wr_data
);

   typedef logic [ADDR_BITS:0]   wide_t;
   typedef logic [ADDR_BITS-1:0] addr_t;

   localparam wide_t PAST_LAST_W = wide_t'(PAST_LAST_ROW);
   localparam wide_t COLS_W      = wide_t'(COLS);
   localparam addr_t LAST_ADDR   = addr_t'(PAST_LAST_ROW - 1);

   // One extra bit holds base + row offset before the single conditional wrap.
   function automatic addr_t wrap_addr(input addr_t base,
                                       input logic [COL_BITS-1:0] x,
                                       input logic [ROW_BITS-1:0] y);
      wide_t sum;
      sum = wide_t'(base) + wide_t'(y) * COLS_W + wide_t'(x);
      if (sum >= PAST_LAST_W) begin
         sum = sum - PAST_LAST_W;
      end
      return sum[ADDR_BITS-1:0];
   endfunction

   function automatic addr_t next_addr(input addr_t a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   state_t state, state_nxt;
   addr_t  first_char_nxt;
   logic   wr_en_nxt;
   addr_t  wr_addr_nxt;
   logic [7:0] wr_data_nxt;
   wide_t  burst_cnt, burst_cnt_nxt;

   logic   ready;
   logic   accept;
   logic   in_range;
   addr_t  start_addr;

   assign cmd_if.cmd_ready = ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         first_char <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         burst_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         first_char <= first_char_nxt;
         wr_en      <= wr_en_nxt;
         wr_addr    <= wr_addr_nxt;
         wr_data    <= wr_data_nxt;
         burst_cnt  <= burst_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      first_char_nxt = first_char;
      wr_en_nxt      = 1'b0;
      wr_addr_nxt    = wr_addr;
      wr_data_nxt    = wr_data;
      burst_cnt_nxt  = burst_cnt;

      ready      = (state == ST_IDLE) && !reset;
      accept     = cmd_if.cmd_valid && ready;
      in_range   = (cmd_if.cmd_x < COL_BITS'(COLS)) && (cmd_if.cmd_y < ROW_BITS'(ROWS));
      start_addr = wrap_addr(first_char, cmd_if.cmd_x, cmd_if.cmd_y);

      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (cmd_if.cmd)
                  CMD_PUT: begin
                     // Off-screen coordinates are a zero-length burst: stay IDLE.
                     if (in_range) begin
                        state_nxt     = ST_WRITE;
                        wr_en_nxt     = 1'b1;
                        wr_addr_nxt   = start_addr;
                        wr_data_nxt   = cmd_if.cmd_char;
                        burst_cnt_nxt = wide_t'(1);
                     end
                  end
                  CMD_SCROLL: begin
                     // The old top row becomes the new bottom row, so blank it.
                     state_nxt      = ST_WRITE;
                     wr_en_nxt      = 1'b1;
                     wr_addr_nxt    = first_char;
                     wr_data_nxt    = FILL_CHAR;
                     burst_cnt_nxt  = COLS_W;
                     first_char_nxt = wrap_addr(first_char, '0, ROW_BITS'(1));
                  end
                  CMD_CLEAR_SCREEN: begin
                     state_nxt      = ST_WRITE;
                     wr_en_nxt      = 1'b1;
                     wr_addr_nxt    = '0;
                     wr_data_nxt    = FILL_CHAR;
                     burst_cnt_nxt  = PAST_LAST_W;
                     first_char_nxt = '0;
                  end
                  default: begin
                     if (in_range) begin
                        state_nxt     = ST_WRITE;
                        wr_en_nxt     = 1'b1;
                        wr_addr_nxt   = start_addr;
                        wr_data_nxt   = FILL_CHAR;
                        burst_cnt_nxt = COLS_W - wide_t'(cmd_if.cmd_x);
                     end
                  end
               endcase
            end
         end
         ST_WRITE: begin
            if (burst_cnt == wide_t'(1)) begin
               state_nxt = ST_IDLE;
            end else begin
               wr_en_nxt     = 1'b1;
               wr_addr_nxt   = next_addr(wr_addr);
               burst_cnt_nxt = burst_cnt - wide_t'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_char_buffer_writer.sv
// tb/tb_char_buffer_writer.sv - self-checking bench for char_buffer_writer
module tb_char_buffer_writer;
   import char_buffer_writer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic [ADDR_BITS-1:0] first_char;
   logic                 wr_en;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [7:0]           wr_data;

   always #5 clk = ~clk;

   char_buffer_writer_if bus();

   char_buffer_writer dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_if     (bus.slave),
      .first_char (first_char),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference model: expected write list and scroll base, from plain modular arithmetic.
   int m_fc;
   int exp_a[$];
   int exp_d[$];

   function automatic void model_apply(input int c, input int ch, input int x, input int y);
      int a;
      exp_a.delete();
      exp_d.delete();
      a = (m_fc + y * COLS + x) % PAST_LAST_ROW;
      case (c)
         0: if (x < COLS && y < ROWS) begin
            exp_a.push_back(a);
            exp_d.push_back(ch);
         end
         1: begin
            for (int i = 0; i < COLS; i++) begin
               exp_a.push_back((m_fc + i) % PAST_LAST_ROW);
               exp_d.push_back(32'h20);
            end
            m_fc = (m_fc + COLS) % PAST_LAST_ROW;
         end
         2: begin
            for (int i = 0; i < PAST_LAST_ROW; i++) begin
               exp_a.push_back(i);
               exp_d.push_back(32'h20);
            end
            m_fc = 0;
         end
         default: if (x < COLS && y < ROWS) begin
            for (int i = 0; i < COLS - x; i++) begin
               exp_a.push_back((a + i) % PAST_LAST_ROW);
               exp_d.push_back(32'h20);
            end
         end
      endcase
   endfunction

   int act_a[$];
   int act_d[$];
   int act_fc;

   task automatic scramble_busy();
      bus.cmd_valid = 1'b1;
      bus.cmd       = 2'($urandom);
      bus.cmd_char  = 8'($urandom);
      bus.cmd_x     = COL_BITS'($urandom);
      bus.cmd_y     = ROW_BITS'($urandom);
   endtask

   task automatic wait_ready();
      int guard = 0;
      @(negedge clk);
      while (bus.cmd_ready !== 1'b1 && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_cmd", bus.cmd_ready, 1);
   endtask

   // Issues one command and records the contiguous write burst that follows it.
   task automatic issue(input int c, input int ch, input int x, input int y);
      int guard = 0;
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd       = 2'(c);
      bus.cmd_char  = 8'(ch);
      bus.cmd_x     = COL_BITS'(x);
      bus.cmd_y     = ROW_BITS'(y);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      act_fc = int'(first_char);
      act_a.delete();
      act_d.delete();
      while (wr_en === 1'b1 && guard < 2100) begin
         act_a.push_back(int'(wr_addr));
         act_d.push_back(int'(wr_data));
         chk("ready_low_during_burst", bus.cmd_ready, 0);
         scramble_busy();
         @(negedge clk);
         guard++;
      end
      bus.cmd_valid = 1'b0;
      chk("ready_after_burst", bus.cmd_ready, 1);
   endtask

   task automatic compare_model(input string tag);
      int n;
      chk({tag, " count"}, act_a.size(), exp_a.size());
      n = (act_a.size() < exp_a.size()) ? act_a.size() : exp_a.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s addr[%0d]", tag, i), act_a[i], exp_a[i]);
         chk($sformatf("%s data[%0d]", tag, i), act_d[i], exp_d[i]);
      end
      chk({tag, " first_char"}, act_fc, m_fc);
   endtask

   task automatic run_model(input int c, input int ch, input int x, input int y, input string tag);
      issue(c, ch, x, y);
      model_apply(c, ch, x, y);
      compare_model(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset cmd_ready", bus.cmd_ready, 0);
      chk("reset wr_en", wr_en, 0);
      chk("reset wr_addr", wr_addr, 0);
      chk("reset wr_data", wr_data, 0);
      chk("reset first_char", first_char, 0);
      reset = 1'b0;
      m_fc = 0;
      @(negedge clk);
      chk("ready_after_reset", bus.cmd_ready, 1);
   endtask

   typedef struct {
      int c; int ch; int x; int y;
      int n; int a_first; int a_last; int d; int fc;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd       = '0;
      bus.cmd_char  = '0;
      bus.cmd_x     = '0;
      bus.cmd_y     = '0;
      reset         = 1'b1;

      tbl[0] = '{c:0, ch:8'h41, x:5,  y:2,  n:1,  a_first:165, a_last:165, d:8'h41, fc:0};
      tbl[1] = '{c:3, ch:0,     x:75, y:0,  n:5,  a_first:75,  a_last:79,  d:8'h20, fc:0};
      tbl[2] = '{c:3, ch:0,     x:80, y:0,  n:0,  a_first:0,   a_last:0,   d:0,     fc:0};
      tbl[3] = '{c:0, ch:8'h5a, x:0,  y:24, n:0,  a_first:0,   a_last:0,   d:0,     fc:0};
      tbl[4] = '{c:1, ch:0,     x:0,  y:0,  n:80, a_first:0,   a_last:79,  d:8'h20, fc:80};
      tbl[5] = '{c:0, ch:8'h42, x:0,  y:0,  n:1,  a_first:80,  a_last:80,  d:8'h42, fc:80};
      tbl[6] = '{c:3, ch:0,     x:79, y:23, n:1,  a_first:79,  a_last:79,  d:8'h20, fc:80};
      tbl[7] = '{c:0, ch:8'h43, x:79, y:23, n:1,  a_first:79,  a_last:79,  d:8'h43, fc:80};

      do_reset();

      for (int i = 0; i < 8; i++) begin
         issue(tbl[i].c, tbl[i].ch, tbl[i].x, tbl[i].y);
         model_apply(tbl[i].c, tbl[i].ch, tbl[i].x, tbl[i].y);
         chk($sformatf("vec%0d count", i), act_a.size(), tbl[i].n);
         if (tbl[i].n > 0 && act_a.size() > 0) begin
            chk($sformatf("vec%0d first addr", i), act_a[0], tbl[i].a_first);
            chk($sformatf("vec%0d last addr", i), act_a[act_a.size()-1], tbl[i].a_last);
            chk($sformatf("vec%0d first data", i), act_d[0], tbl[i].d);
            chk($sformatf("vec%0d last data", i), act_d[act_d.size()-1], tbl[i].d);
         end
         chk($sformatf("vec%0d first_char", i), act_fc, tbl[i].fc);
      end

      // 23 scrolls reach the last row base; the next row down wraps to address 0.
      do_reset();
      for (int i = 0; i < 23; i++) run_model(CMD_SCROLL, 0, 0, 0, "scroll23");
      chk("first_char after 23 scrolls", first_char, 1840);
      run_model(CMD_PUT, 8'h61, 0, 1, "put_wrap");
      if (act_a.size() > 0) chk("put_wrap addr", act_a[0], 0);
      run_model(CMD_SCROLL, 0, 0, 0, "scroll24");
      chk("first_char after 24 scrolls", act_fc, 0);
      if (act_a.size() == COLS) begin
         chk("scroll24 first addr", act_a[0], 1840);
         chk("scroll24 last addr", act_a[COLS-1], 1919);
      end

      do_reset();
      for (int i = 0; i < 3; i++) run_model(CMD_SCROLL, 0, 0, 0, "pre_clear");
      run_model(CMD_CLEAR_SCREEN, 0, 0, 0, "clear");

      // Reset lands after the 100th write of a clear-screen burst.
      do_reset();
      run_model(CMD_SCROLL, 0, 0, 0, "pre_abort");
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd       = CMD_CLEAR_SCREEN;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (99) @(negedge clk);
      chk("abort 100th wr_en", wr_en, 1);
      chk("abort 100th wr_addr", wr_addr, 99);
      reset = 1'b1;
      @(negedge clk);
      chk("abort wr_en", wr_en, 0);
      chk("abort first_char", first_char, 0);
      chk("abort ready in reset", bus.cmd_ready, 0);
      reset = 1'b0;
      m_fc = 0;
      @(negedge clk);
      chk("abort ready after reset", bus.cmd_ready, 1);
      run_model(CMD_PUT, 8'h51, 3, 1, "post_abort_put");

      for (int i = 0; i < 30; i++) begin
         int r, c, x, y, ch;
         r  = $urandom_range(0, 99);
         c  = (r < 45) ? 0 : (r < 72) ? 3 : (r < 94) ? 1 : 2;
         x  = $urandom_range(0, 90);
         y  = $urandom_range(0, 27);
         ch = $urandom_range(0, 255);
         run_model(c, ch, x, y, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
